// File: rtl/paddle_ctrl_n.sv
// N-player paddle controller: synchronised/debounced buttons, tick-paced moves with slow-to-fast acceleration, screen clamping.
// Optional `define PADDLE_AI_EN adds ball_y/ai_mode inputs that let a paddle track the ball.
module paddle_ctrl_n #(
    parameter int NUM_PADDLES = 2,
    parameter int POS_W       = 10,
    parameter int SCREEN_H    = 480,
    parameter int PADDLE_H    = 80,
    parameter int TICK_DIV    = 800000,
    parameter int DEB_CYCLES  = 480000,
    parameter int STEP_SLOW   = 2,
    parameter int STEP_FAST   = 6,
    parameter int ACCEL_TICKS = 15
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PADDLES-1:0]         btn_up,
    input  logic [NUM_PADDLES-1:0]         btn_dn,
    input  logic                           freeze,
`ifdef PADDLE_AI_EN
    input  logic [POS_W-1:0]               ball_y,
    input  logic [NUM_PADDLES-1:0]         ai_mode,
`endif
    output logic [NUM_PADDLES*POS_W-1:0]   pos_y,
    output logic [NUM_PADDLES-1:0]         moving,
    output logic                           frame_tick
);
    localparam int NB     = 2 * NUM_PADDLES;
    localparam int EXT_W  = POS_W + 1;
    localparam int TICK_W = $clog2(TICK_DIV + 1);
    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] ACCEL_N    = HOLD_W'(ACCEL_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam logic [EXT_W-1:0]  POS_MAX    = EXT_W'(SCREEN_H - PADDLE_H);
    localparam logic [POS_W-1:0]  POS_RST    = POS_W'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [EXT_W-1:0]  STEP_S     = EXT_W'(STEP_SLOW);
    localparam logic [EXT_W-1:0]  STEP_F     = EXT_W'(STEP_FAST);
`ifdef PADDLE_AI_EN
    localparam logic [EXT_W-1:0]  HALF_H     = EXT_W'(PADDLE_H / 2);
    localparam logic [EXT_W-1:0]  AI_BAND    = EXT_W'(4);
`endif

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SLOW = 2'd1, ST_FAST = 2'd2} state_t;
    typedef enum logic [1:0] {DIR_NONE = 2'd0, DIR_UP = 2'd1, DIR_DN = 2'd2} dir_t;

    // Button bit b: up buttons in the low half, down buttons in the high half.
    logic [NB-1:0]     w_btn_raw;
    logic [NB-1:0]     r_btn_meta, r_btn_sync, r_btn_deb;
    logic [DEB_W-1:0]  r_deb_cnt [NB];
    logic [TICK_W-1:0] r_tick_cnt;
    logic              r_frame_tick;

    state_t            r_state [NUM_PADDLES];
    dir_t              r_dir   [NUM_PADDLES];
    logic [HOLD_W-1:0] r_hold  [NUM_PADDLES];
    logic [POS_W-1:0]  r_pos   [NUM_PADDLES];
    logic [NUM_PADDLES-1:0] r_moving;

    state_t            w_state_nxt [NUM_PADDLES];
    dir_t              w_dir_nxt   [NUM_PADDLES];
    dir_t              w_dir       [NUM_PADDLES];
    dir_t              w_mv_dir    [NUM_PADDLES];
    logic [HOLD_W-1:0] w_hold_nxt  [NUM_PADDLES];
    logic [HOLD_W-1:0] w_hold_inc  [NUM_PADDLES];
    logic [EXT_W-1:0]  w_step      [NUM_PADDLES];
    logic [EXT_W-1:0]  w_pos_ext   [NUM_PADDLES];
    logic [EXT_W-1:0]  w_pos_sum   [NUM_PADDLES];
    logic [EXT_W-1:0]  w_pos_new   [NUM_PADDLES];
    logic [POS_W-1:0]  w_pos_nxt   [NUM_PADDLES];
    logic [NUM_PADDLES-1:0] w_move_nxt;
`ifdef PADDLE_AI_EN
    logic [EXT_W-1:0]  w_centre    [NUM_PADDLES];
    logic [EXT_W-1:0]  w_ball_ext;
`endif

    assign w_btn_raw = {btn_dn, btn_up};

    // Two-flop synchroniser and per-button debounce counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn_meta <= '0;
            r_btn_sync <= '0;
            r_btn_deb  <= '0;
            for (int b = 0; b < NB; b++) r_deb_cnt[b] <= '0;
        end else begin
            r_btn_meta <= w_btn_raw;
            r_btn_sync <= r_btn_meta;
            for (int b = 0; b < NB; b++) begin
                if (r_btn_sync[b] == r_btn_deb[b]) begin
                    r_deb_cnt[b] <= '0;
                end else if (r_deb_cnt[b] == DEB_LAST) begin
                    r_btn_deb[b] <= r_btn_sync[b];
                    r_deb_cnt[b] <= '0;
                end else begin
                    r_deb_cnt[b] <= r_deb_cnt[b] + DEB_W'(1);
                end
            end
        end
    end

    // Free-running movement tick divider.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt   <= '0;
            r_frame_tick <= 1'b0;
        end else if (r_tick_cnt == TICK_LAST) begin
            r_tick_cnt   <= '0;
            r_frame_tick <= 1'b1;
        end else begin
            r_tick_cnt   <= r_tick_cnt + TICK_W'(1);
            r_frame_tick <= 1'b0;
        end
    end

    // Per-paddle next-state, step selection and clamped position.
    always_comb begin
`ifdef PADDLE_AI_EN
        w_ball_ext = {1'b0, ball_y};
`endif
        for (int i = 0; i < NUM_PADDLES; i++) begin
            if (r_btn_deb[i] && !r_btn_deb[NUM_PADDLES+i]) begin
                w_dir[i] = DIR_UP;
            end else if (!r_btn_deb[i] && r_btn_deb[NUM_PADDLES+i]) begin
                w_dir[i] = DIR_DN;
            end else begin
                w_dir[i] = DIR_NONE;
            end
            w_state_nxt[i] = r_state[i];
            w_dir_nxt[i]   = r_dir[i];
            w_hold_nxt[i]  = r_hold[i];
            w_hold_inc[i]  = r_hold[i] + HOLD_ONE;
            w_mv_dir[i]    = DIR_NONE;
            w_step[i]      = '0;

            case (r_state[i])
                ST_IDLE: begin
                    if (w_dir[i] != DIR_NONE) begin
                        w_state_nxt[i] = ST_SLOW;
                        w_dir_nxt[i]   = w_dir[i];
                        w_hold_nxt[i]  = HOLD_ONE;
                        w_mv_dir[i]    = w_dir[i];
                        w_step[i]      = STEP_S;
                    end else begin
                        w_hold_nxt[i]  = '0;
                    end
                end
                ST_SLOW, ST_FAST: begin
                    if (w_dir[i] == DIR_NONE) begin
                        w_state_nxt[i] = ST_IDLE;
                        w_dir_nxt[i]   = DIR_NONE;
                        w_hold_nxt[i]  = '0;
                    end else if (w_dir[i] != r_dir[i]) begin
                        w_state_nxt[i] = ST_SLOW;
                        w_dir_nxt[i]   = w_dir[i];
                        w_hold_nxt[i]  = HOLD_ONE;
                        w_mv_dir[i]    = w_dir[i];
                        w_step[i]      = STEP_S;
                    end else if (r_state[i] == ST_FAST) begin
                        w_mv_dir[i]    = w_dir[i];
                        w_step[i]      = STEP_F;
                    end else begin
                        w_hold_nxt[i]  = w_hold_inc[i];
                        w_mv_dir[i]    = w_dir[i];
                        w_step[i]      = STEP_S;
                        if (w_hold_inc[i] == ACCEL_N) begin
                            w_state_nxt[i] = ST_FAST;
                        end else begin
                            w_state_nxt[i] = ST_SLOW;
                        end
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_IDLE;
                    w_dir_nxt[i]   = DIR_NONE;
                    w_hold_nxt[i]  = '0;
                end
            endcase

`ifdef PADDLE_AI_EN
            w_centre[i] = {1'b0, r_pos[i]} + HALF_H;
            if (ai_mode[i]) begin
                w_state_nxt[i] = ST_IDLE;
                w_dir_nxt[i]   = DIR_NONE;
                w_hold_nxt[i]  = '0;
                w_step[i]      = STEP_S;
                if (w_ball_ext > w_centre[i] + AI_BAND) begin
                    w_mv_dir[i] = DIR_DN;
                end else if (w_ball_ext + AI_BAND < w_centre[i]) begin
                    w_mv_dir[i] = DIR_UP;
                end else begin
                    w_mv_dir[i] = DIR_NONE;
                end
            end else begin
                w_centre[i] = w_centre[i];
            end
`endif

            if (freeze) begin
                w_state_nxt[i] = ST_IDLE;
                w_dir_nxt[i]   = DIR_NONE;
                w_hold_nxt[i]  = '0;
                w_mv_dir[i]    = DIR_NONE;
                w_step[i]      = '0;
            end else begin
                w_mv_dir[i]    = w_mv_dir[i];
            end

            // One spare bit keeps the add/subtract free of wrap-around before clamping.
            w_pos_ext[i] = {1'b0, r_pos[i]};
            w_pos_sum[i] = w_pos_ext[i] + w_step[i];
            case (w_mv_dir[i])
                DIR_UP:  w_pos_new[i] = (w_pos_ext[i] < w_step[i]) ? '0 : (w_pos_ext[i] - w_step[i]);
                DIR_DN:  w_pos_new[i] = (w_pos_sum[i] > POS_MAX) ? POS_MAX : w_pos_sum[i];
                default: w_pos_new[i] = w_pos_ext[i];
            endcase
            w_pos_nxt[i]  = w_pos_new[i][POS_W-1:0];
            w_move_nxt[i] = (w_pos_new[i] != w_pos_ext[i]);
        end
    end

    // Paddle state commits only on the edge that sees the frame tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_moving <= '0;
            for (int i = 0; i < NUM_PADDLES; i++) begin
                r_state[i] <= ST_IDLE;
                r_dir[i]   <= DIR_NONE;
                r_hold[i]  <= '0;
                r_pos[i]   <= POS_RST;
            end
        end else if (r_frame_tick) begin
            r_moving <= w_move_nxt;
            for (int i = 0; i < NUM_PADDLES; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_dir[i]   <= w_dir_nxt[i];
                r_hold[i]  <= w_hold_nxt[i];
                r_pos[i]   <= w_pos_nxt[i];
            end
        end
    end

    // Pack per-paddle positions onto the output bus.
    always_comb begin
        pos_y = '0;
        for (int i = 0; i < NUM_PADDLES; i++) pos_y[i*POS_W +: POS_W] = r_pos[i];
    end

    assign moving     = r_moving;
    assign frame_tick = r_frame_tick;
endmodule

// File: tb/tb_paddle_ctrl_n.sv
// Directed self-checking bench for paddle_ctrl_n with short tick/debounce/acceleration settings.
module tb_paddle_ctrl_n;
    logic        clk;
    logic        reset;
    logic [1:0]  btn_up;
    logic [1:0]  btn_dn;
    logic        freeze;
    logic [19:0] pos_y;
    logic [1:0]  moving;
    logic        frame_tick;

    int total_cnt = 0;
    int bad_cnt   = 0;

    paddle_ctrl_n #(
        .NUM_PADDLES(2), .POS_W(10), .SCREEN_H(480), .PADDLE_H(80),
        .TICK_DIV(4), .DEB_CYCLES(3), .STEP_SLOW(2), .STEP_FAST(6), .ACCEL_TICKS(3)
    ) dut (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_dn(btn_dn), .freeze(freeze),
        .pos_y(pos_y), .moving(moving), .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        total_cnt++;
        if (got != exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Returns on the falling edge just after the position update edge.
    task automatic tick_chk(input string tag, input int e0, input int e1, input int em);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (frame_tick) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq({tag, "_tick_seen"}, int'(seen), 1);
        @(negedge clk);
        check_eq({tag, "_p0"}, int'(pos_y[9:0]), e0);
        check_eq({tag, "_p1"}, int'(pos_y[19:10]), e1);
        check_eq({tag, "_mov"}, int'(moving), em);
    endtask

    initial begin
        int e0;
        int e1;
        int n;
        reset = 1'b0; btn_up = 2'b00; btn_dn = 2'b00; freeze = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_p0", int'(pos_y[9:0]), 200);
        check_eq("rst_p1", int'(pos_y[19:10]), 200);
        check_eq("rst_mov", int'(moving), 0);
        check_eq("rst_tick", int'(frame_tick), 0);
        reset = 1'b1;

        // Acceleration on paddle 0
        tick_chk("acc_sync", 200, 200, 0);
        btn_up[0] = 1'b1;
        tick_chk("acc_deb", 200, 200, 0);
        tick_chk("acc_s1", 198, 200, 1);
        tick_chk("acc_s2", 196, 200, 1);
        tick_chk("acc_s3", 194, 200, 1);
        tick_chk("acc_f1", 188, 200, 1);
        tick_chk("acc_f2", 182, 200, 1);
        btn_up[0] = 1'b0;
        tick_chk("acc_rel", 176, 200, 1);
        tick_chk("acc_idle", 176, 200, 0);

        // Two-cycle glitch must be rejected
        btn_dn[1] = 1'b1;
        repeat (2) @(negedge clk);
        btn_dn[1] = 1'b0;
        tick_chk("glitch_a", 176, 200, 0);
        tick_chk("glitch_b", 176, 200, 0);

        // Held down on paddle 1 to the bottom clamp
        btn_dn[1] = 1'b1;
        tick_chk("dn_deb", 176, 200, 0);
        tick_chk("dn_s1", 176, 202, 2);
        tick_chk("dn_s2", 176, 204, 2);
        tick_chk("dn_s3", 176, 206, 2);
        e1 = 206;
        for (int k = 0; k < 32; k++) begin
            e1 = e1 + 6;
            tick_chk("dn_fast", 176, e1, 2);
        end
        tick_chk("dn_clamp", 176, 400, 2);
        tick_chk("dn_hold", 176, 400, 0);
        btn_dn[1] = 1'b0;
        tick_chk("dn_rel", 176, 400, 0);
        tick_chk("dn_idle", 176, 400, 0);

        // Both buttons on paddle 1 at the bottom: must not move up
        btn_up[1] = 1'b1; btn_dn[1] = 1'b1;
        tick_chk("both1_deb", 176, 400, 0);
        tick_chk("both1_a", 176, 400, 0);
        tick_chk("both1_b", 176, 400, 0);
        btn_up[1] = 1'b0; btn_dn[1] = 1'b0;

        // Reversal and freeze on paddle 0
        btn_up[0] = 1'b1;
        tick_chk("rev_deb", 176, 400, 0);
        tick_chk("rev_s1", 174, 400, 1);
        tick_chk("rev_s2", 172, 400, 1);
        tick_chk("rev_s3", 170, 400, 1);
        tick_chk("rev_f1", 164, 400, 1);
        btn_up[0] = 1'b0; btn_dn[0] = 1'b1;
        tick_chk("rev_old", 158, 400, 1);
        tick_chk("rev_slow", 160, 400, 1);
        freeze = 1'b1;
        tick_chk("frz_a", 160, 400, 0);
        tick_chk("frz_b", 160, 400, 0);
        tick_chk("frz_c", 160, 400, 0);
        freeze = 1'b0;
        tick_chk("frz_rel1", 162, 400, 1);
        tick_chk("frz_rel2", 164, 400, 1);

        // Drive paddle 0 up to the top clamp through an exact 4
        btn_up[0] = 1'b1; btn_dn[0] = 1'b0;
        tick_chk("up_old", 166, 400, 1);
        tick_chk("up_s1", 164, 400, 1);
        tick_chk("up_s2", 162, 400, 1);
        tick_chk("up_s3", 160, 400, 1);
        e0 = 160;
        for (int k = 0; k < 26; k++) begin
            e0 = e0 - 6;
            tick_chk("up_fast", e0, 400, 1);
        end
        tick_chk("up_clamp", 0, 400, 1);
        tick_chk("up_hold", 0, 400, 0);

        // Both buttons on paddle 0 at the top: must not move down
        btn_dn[0] = 1'b1;
        tick_chk("both0_old", 0, 400, 0);
        tick_chk("both0_a", 0, 400, 0);
        btn_up[0] = 1'b0;
        tick_chk("both0_b", 0, 400, 0);
        tick_chk("mv_dn", 2, 400, 1);

        // Asynchronous reset mid-run
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("mid_rst_p0", int'(pos_y[9:0]), 200);
        check_eq("mid_rst_p1", int'(pos_y[19:10]), 200);
        check_eq("mid_rst_mov", int'(moving), 0);
        check_eq("mid_rst_tick", int'(frame_tick), 0);
        btn_dn = 2'b00; btn_up = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            n++;
            if (frame_tick) break;
        end
        check_eq("first_tick_gap", n, 4);
        n = 0;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            n++;
            if (frame_tick) break;
            @(negedge clk);
        end
        check_eq("tick_period", n, 4);
        check_eq("post_rst_p0", int'(pos_y[9:0]), 200);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule

// File: doc/paddle_ctrl_n.md
Name: paddle_ctrl_n

Overview:
- Parametrised N-player paddle position controller for the VGA pong design; successor to the fixed two-paddle left/right bar controllers.
- Per paddle: synchronises and debounces up/down pushbuttons, moves on a frame-rate tick with slow-to-fast acceleration, and clamps to the screen.
- Drives packed vertical positions to the renderer and the position block; also exports the frame tick.

Parameters:
- NUM_PADDLES, 2, number of independent paddles.
- POS_W, 10, position width in bits.
- SCREEN_H, 480, visible lines.
- PADDLE_H, 80, paddle height in lines; max position = SCREEN_H-PADDLE_H.
- TICK_DIV, 800000, clk cycles per movement tick (60 Hz at 48 MHz).
- DEB_CYCLES, 480000, consecutive stable cycles required to accept a button change (10 ms).
- STEP_SLOW, 2, lines per tick in SLOW.
- STEP_FAST, 6, lines per tick in FAST.
- ACCEL_TICKS, 15, consecutive moving ticks before SLOW->FAST.

Ports:
- clk  in  1  system clock (48 MHz HSOSC).
- reset  in  1  asynchronous active-low reset.
- btn_up  in  NUM_PADDLES  raw up buttons, active-high, asynchronous to clk.
- btn_dn  in  NUM_PADDLES  raw down buttons, active-high, asynchronous to clk.
- freeze  in  1  synchronous hold; no movement while high.
- pos_y  out  NUM_PADDLES*POS_W  packed top-edge positions; paddle i at [i*POS_W +: POS_W].
- moving  out  NUM_PADDLES  paddle i changed position on the last tick.
- frame_tick  out  1  one-cycle pulse every TICK_DIV cycles.

Behaviour:
- Reset (reset=0, async): every pos_y field = (SCREEN_H-PADDLE_H)/2 (200 with defaults); moving=0; frame_tick=0; all FSMs IDLE; debounced states 0; tick and debounce counters 0.
- Input sync: 2-FF synchroniser per raw button.
- Debounce: per button, a counter runs while the synced level differs from the debounced level and clears when they match. Debounced level flips when the counter reaches DEB_CYCLES-1.
- Tick: counter counts 0..TICK_DIV-1 and wraps. frame_tick is registered and high for the one cycle after the counter equals TICK_DIV-1.
- Update timing: pos_y, moving and FSM state update only on the clk edge that samples frame_tick=1. The new pos_y is visible the following cycle.
- Direction per paddle: UP if only up is debounced-active, DN if only dn is active, NONE otherwise (neither or both).
- Per-paddle FSM, evaluated on tick; hold is a counter:
  - IDLE: dir NONE -> stay, no move. Dir UP/DN -> move STEP_SLOW, hold=1, go SLOW, latch dir.
  - SLOW: dir NONE -> IDLE, no move. Dir changed -> move STEP_SLOW in new dir, hold=1, stay SLOW. Same dir -> move STEP_SLOW, hold+1; if hold+1 == ACCEL_TICKS, go FAST.
  - FAST: dir NONE -> IDLE, no move. Dir changed -> move STEP_SLOW in new dir, hold=1, go SLOW. Same dir -> move STEP_FAST.
- Arithmetic: UP decreases y. UP saturates at 0, DN saturates at SCREEN_H-PADDLE_H. Compute in POS_W+1 bits; no wrap-around.
- moving[i] = 1 iff pos_y field i changed on this tick. A move clamped to the same value gives 0. Value holds until the next tick.
- freeze=1 on tick: positions hold, all FSMs -> IDLE, moving=0. Debounce and tick counters keep running.
- Reset mid-move returns everything to reset values immediately.
- Paddles are fully independent; no cross-paddle interaction.

Optional Feature:
- Macro: PADDLE_AI_EN.
- Defined: adds input ball_y (POS_W) and input ai_mode (NUM_PADDLES).
  - For paddle i with ai_mode[i]=1, buttons are ignored, FSM held IDLE, hold=0.
  - On each tick, with centre = pos+PADDLE_H/2: if ball_y > centre+4, move DN STEP_SLOW; if ball_y < centre-4, move UP STEP_SLOW; else no move.
  - Same clamping; freeze still has priority.
- Undefined: ports absent; all paddles button-driven only.

Test Plan:
- Bench params for all scenarios: TICK_DIV=4, DEB_CYCLES=3, ACCEL_TICKS=3, defaults otherwise.
- Reset: assert reset=0 mid-run -> both pos_y=200, moving=0, frame_tick=0 immediately; release -> frame_tick every 4th cycle.
- Acceleration: hold btn_up[0] -> paddle 0 per tick 198,196,194,188,182; paddle 1 stays 200; release -> IDLE, moving[0]=0 on next tick.
- Debounce: 2-cycle glitch on btn_dn[1] -> no movement; held 3+ cycles then tick -> 202.
- Clamp and both-pressed: drive paddle 0 to 4 in FAST, hold up -> 0, moving=1, then 0, moving=0. Drive paddle 1 down -> 400 max, never 401+. Both buttons pressed -> no move.
- Reversal and freeze: FAST up then switch to dn -> +2 (SLOW). freeze=1 across 3 ticks -> pos constant, moving=0. Release with button held -> restarts SLOW.
